// File: rtl/cache_control.sv
// Sequencing FSM for the 4-way write-back/write-allocate cache datapath.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
//
// state       | meaning
// IDLE        | waiting for a CPU request, all outputs low
// COMPARE     | tag compare; hit completes, miss picks writeback or refill
// WRITEBACK   | dirty PLRU victim written to pmem
// ALLOCATE    | line fetched from pmem and written into the victim way
// REFILL_WAIT | one cycle for the synchronous array read-back
module cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit_sig,
    input  logic                 dirty_sig,
    output logic                 allo_sig,
    output logic                 rep_sig,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 load_plru,
    output logic                 valid_i,
    output logic                 dirty_i
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        REFILL_WAIT
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        allo_sig   = 1'b0;
        rep_sig    = 1'b0;
        load_data  = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        load_plru  = 1'b0;
        valid_i    = 1'b0;
        dirty_i    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit_sig) begin
                    mem_resp  = 1'b1;
                    load_plru = 1'b1;
                    // a simultaneous read+write request is serviced as a write
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_i    = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = dirty_sig ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                rep_sig    = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                allo_sig  = 1'b1;
                rep_sig   = 1'b1;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    valid_i    = 1'b1;
                    load_dirty = 1'b1;
                    dirty_i    = 1'b0;
                    state_d    = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                state_d = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic                 from_refill_q, from_refill_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

    // the guaranteed hit after a refill is not a real CPU hit
    always_comb begin
        from_refill_d = (state_q == REFILL_WAIT);
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        wb_cnt_d      = wb_cnt_q;
        if (state_q == COMPARE && hit_sig && !from_refill_q && hit_cnt_q != '1)
            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        if (state_q == COMPARE && !hit_sig && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        if (state_q == WRITEBACK && pmem_resp && wb_cnt_q != '1)
            wb_cnt_d = wb_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            from_refill_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            from_refill_q <= from_refill_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            wb_cnt_q      <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    // counters compiled out; CNT_WIDTH only sizes them when enabled
    if (CNT_WIDTH > 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with a small tag-store and pmem model.
// Counter checks are included when CACHE_PERF_CNT_EN is defined.
module tb_cache_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, mem_resp;
    logic pmem_read, pmem_write, pmem_resp;
    logic hit_sig, dirty_sig;
    logic allo_sig, rep_sig, load_data, load_tag, load_valid, load_dirty, load_plru;
    logic valid_i, dirty_i;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit_sig(hit_sig), .dirty_sig(dirty_sig),
        .allo_sig(allo_sig), .rep_sig(rep_sig),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .load_plru(load_plru),
        .valid_i(valid_i), .dirty_i(dirty_i)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    wire [11:0] outs = {mem_resp, pmem_read, pmem_write, allo_sig, rep_sig, load_data,
                        load_tag, load_valid, load_dirty, load_plru, valid_i, dirty_i};

    // tag store: 8 sets x 4 ways, FIFO victim standing in for PLRU
    logic [31:0] addr;
    logic [23:0] tg [8][4];
    logic        vl [8][4];
    logic        dy [8][4];
    logic [1:0]  vic [8];
    logic [1:0]  hit_way;
    wire  [2:0]  set_i = addr[7:5];
    wire  [23:0] tag_i = addr[31:8];

    always_comb begin
        hit_sig = 1'b0;
        hit_way = 2'd0;
        for (int w = 0; w < 4; w++)
            if (vl[set_i][w] && tg[set_i][w] == tag_i) begin
                hit_sig = 1'b1;
                hit_way = w[1:0];
            end
        dirty_sig = vl[set_i][vic[set_i]] && dy[set_i][vic[set_i]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                vic[s] <= 2'd0;
                for (int w = 0; w < 4; w++) begin
                    vl[s][w] <= 1'b0;
                    dy[s][w] <= 1'b0;
                end
            end
        end else if (load_tag) begin
            tg[set_i][vic[set_i]] <= tag_i;
            vl[set_i][vic[set_i]] <= valid_i;
            dy[set_i][vic[set_i]] <= dirty_i;
            vic[set_i]            <= vic[set_i] + 2'd1;
        end else if (load_dirty && hit_sig) begin
            dy[set_i][hit_way] <= dirty_i;
        end
    end

    // pmem: responds after mem_lat waiting cycles, one-cycle pulse
    int   mem_lat = 0;
    int   wait_cnt = 0;
    logic resp_mdl = 1'b0;
    logic resp_force = 1'b0;
    logic overlap = 1'b0;
    assign pmem_resp = resp_mdl | resp_force;

    always @(negedge clk) begin
        if (pmem_read && pmem_write) overlap = 1'b1;
        if (pmem_read || pmem_write) begin
            if (wait_cnt >= mem_lat) begin
                resp_mdl = 1'b1;
                wait_cnt = 0;
            end else begin
                resp_mdl = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_mdl = 1'b0;
            wait_cnt = 0;
        end
    end

    // latency counts the request cycle as 1 and the mem_resp cycle inclusive
    task automatic do_req(input logic [31:0] a, input logic rd, input logic wr,
                          output int lat, output logic saw_r, output logic saw_w,
                          output logic wr_first, output logic [11:0] resp_o,
                          output logic [3:0] alloc_o, output logic [5:0] fill_o);
        bit done = 0;
        lat = 0; saw_r = 0; saw_w = 0; wr_first = 0;
        resp_o = '0; alloc_o = '0; fill_o = '0;
        @(negedge clk);
        addr = a; mem_read = rd; mem_write = wr;
        for (int i = 1; i <= 100 && !done; i++) begin
            #1;
            if (pmem_write && !saw_r && !saw_w) wr_first = 1'b1;
            if (pmem_read && !saw_r) alloc_o = {allo_sig, rep_sig, pmem_read, pmem_write};
            if (pmem_read && pmem_resp)
                fill_o = {load_data, load_tag, load_valid, valid_i, load_dirty, dirty_i};
            saw_r |= pmem_read;
            saw_w |= pmem_write;
            if (mem_resp) begin
                lat = i; resp_o = outs; done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("req_timeout", 64'd0, 64'd1);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    int         lat;
    logic       sr, sw, wf;
    logic [11:0] ro;
    logic [3:0] ao;
    logic [5:0] fo;
    bit         seen;

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0;
        @(negedge clk);
        #1 check("rst_outs", outs, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("idle_outs", outs, 12'h000);

        do_req(32'h0000_0040, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("cold_lat", lat, 5);
        check("cold_pmem_rw", {sr, sw}, 2'b10);
        check("cold_alloc", ao, 4'b1110);
        check("cold_fill", fo, 6'b111110);
        check("cold_resp", ro, 12'h804);

        do_req(32'h0000_0040, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("reread_lat", lat, 2);
        check("reread_pmem", {sr, sw}, 2'b00);
        check("reread_resp", ro, 12'h804);

        do_req(32'h0000_0044, 1'b0, 1'b1, lat, sr, sw, wf, ro, ao, fo);
        check("whit_lat", lat, 2);
        check("whit_resp", ro, 12'h84D);

        for (int k = 1; k <= 3; k++) begin
            do_req(32'h0000_0040 + 32'(k) * 32'h100, 1'b0, 1'b1, lat, sr, sw, wf, ro, ao, fo);
            check($sformatf("fill_lat_%0d", k), lat, 5);
            check($sformatf("fill_pmem_%0d", k), {sr, sw}, 2'b10);
            check($sformatf("fill_resp_%0d", k), ro, 12'h84D);
        end

        do_req(32'h0000_0440, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("evict_lat", lat, 6);
        check("evict_pmem", {sr, sw}, 2'b11);
        check("evict_wr_first", wf, 1'b1);
`ifdef CACHE_PERF_CNT_EN
        check("perf_hit_a", hit_cnt, 2);
        check("perf_miss_a", miss_cnt, 5);
        check("perf_wb_a", wb_cnt, 1);
`endif

        mem_lat = 3;
        do_req(32'h0000_0540, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("slow_evict_lat", lat, 12);
        check("slow_evict_wr_first", wf, 1'b1);

        mem_lat = 0;
        do_req(32'h0000_0440, 1'b1, 1'b1, lat, sr, sw, wf, ro, ao, fo);
        check("rw_both_lat", lat, 2);
        check("rw_both_resp", ro, 12'h84D);

        mem_lat = 5;
        @(negedge clk);
        addr = 32'h0000_0640; mem_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (pmem_read) seen = 1;
            else @(negedge clk);
        end
        check("wait_pmem_read", seen, 1'b1);
        rst = 1'b1;
        #1 check("rst_mid_drop", {pmem_read, mem_resp}, 2'b00);
        check("rst_mid_outs", outs, 12'h000);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("post_rst_outs", outs, 12'h000);
`ifdef CACHE_PERF_CNT_EN
        check("perf_clear", {hit_cnt, miss_cnt} | 64'(wb_cnt), 64'd0);
`endif

        mem_lat = 0;
        do_req(32'h0000_0440, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("post_rst_miss_lat", lat, 5);

        @(negedge clk);
        resp_force = 1'b1;
        #1 check("spurious_resp_outs", outs, 12'h000);
        @(negedge clk);
        resp_force = 1'b0;
        do_req(32'h0000_0440, 1'b1, 1'b0, lat, sr, sw, wf, ro, ao, fo);
        check("spurious_then_hit_lat", lat, 2);
        check("spurious_then_hit_pmem", {sr, sw}, 2'b00);
`ifdef CACHE_PERF_CNT_EN
        check("perf_hit_b", hit_cnt, 1);
        check("perf_miss_b", miss_cnt, 1);
        check("perf_wb_b", wb_cnt, 0);
`endif
        check("pmem_overlap", overlap, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
